// File: rtl/result_bcd_display_if.sv
// ----------------------------------------------------------------------------
// result_bcd_display_if
// Groups the request/response signals between the calculator controller (the
// master) and the binary-to-BCD converter (the slave).
//   result       master->slave  value to convert (two's complement when signed)
//   result_valid master->slave  conversion request
//   busy         slave->master  conversion in progress
//   done         slave->master  one-cycle pulse; output set updated this cycle
//   bcd_out      slave->master  magnitude digits, [3:0] is the ones digit
//   negative     slave->master  sign of the last converted value
//   digit_blank  slave->master  bit i set: digit i is a leading zero
// ----------------------------------------------------------------------------
interface result_bcd_display_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic [WIDTH-1:0]    result;
    logic                result_valid;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd_out;
    logic                negative;
    logic [DIGITS-1:0]   digit_blank;

    modport master (
        output result,
        output result_valid,
        input  busy,
        input  done,
        input  bcd_out,
        input  negative,
        input  digit_blank
    );

    modport slave (
        input  result,
        input  result_valid,
        output busy,
        output done,
        output bcd_out,
        output negative,
        output digit_blank
    );
endinterface

// File: rtl/result_bcd_display.sv
// ----------------------------------------------------------------------------
// result_bcd_display
// Sequential double-dabble converter: turns the controller's WIDTH-bit result
// into a sign flag plus DIGITS BCD digits for the 7-segment mux, one shift per
// clock, with a start/done handshake.
// Ports:
//   clk  in  system clock, rising edge
//   RST  in  synchronous active-high reset (aborts a running conversion)
//   bus  slave modport of result_bcd_display_if (request and output set)
// ----------------------------------------------------------------------------
module result_bcd_display #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5,
    parameter int SIGNED = 1
) (
    input  logic                    clk,
    input  logic                    RST,
    result_bcd_display_if.slave     bus
);
    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTH-1:0]  mag_q, mag_d;
    logic [SW-1:0]     scratch_q, scratch_d;
    logic              neg_q, neg_d;
    logic [SW-1:0]     bcd_q, bcd_d;
    logic              negative_q, negative_d;
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              done_q, done_d;

    logic [SW-1:0]     adj_s;
    logic [DIGITS-1:0] blank_s;
    logic              in_neg_s;
    logic [WIDTH-1:0]  abs_s;

    // Reset value of digit_blank: every digit but the ones digit is blanked.
    localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    // Sign and magnitude of the incoming request; magnitude is unsigned so the
    // most negative value maps to 2**(WIDTH-1).
    always_comb begin
        in_neg_s = 1'b0;
        abs_s    = bus.result;
        if (SIGNED != 0) begin
            in_neg_s = bus.result[WIDTH-1];
        end else begin
            in_neg_s = 1'b0;
        end
        if (in_neg_s) begin
            abs_s = ~bus.result + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            abs_s = bus.result;
        end
    end

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    always_comb begin
        adj_s = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj_s[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end else begin
                adj_s[4*i +: 4] = scratch_q[4*i +: 4];
            end
        end
    end

    // Leading-zero map: digit i is blank when it and every higher digit is zero;
    // the ones digit always shows.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank_s    = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (scratch_q[4*i +: 4] == 4'd0);
            blank_s[i] = zero_above;
        end
        blank_s[0] = 1'b0;
    end

    // Next-state and datapath control for IDLE -> SHIFT -> DONE -> IDLE.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        mag_d      = mag_q;
        scratch_d  = scratch_q;
        neg_d      = neg_q;
        bcd_d      = bcd_q;
        negative_d = negative_q;
        blank_d    = blank_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.result_valid) begin
                    neg_d     = in_neg_s;
                    mag_d     = abs_s;
                    scratch_d = '0;
                    count_d   = '0;
                    state_d   = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                scratch_d = {adj_s[SW-2:0], mag_q[WIDTH-1]};
                mag_d     = {mag_q[WIDTH-2:0], 1'b0};
                count_d   = count_q + {{(CW-1){1'b0}}, 1'b1};
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                // Outputs only ever change here, so no partial shift data leaks.
                bcd_d      = scratch_q;
                negative_d = neg_q;
                blank_d    = blank_s;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q    <= IDLE;
            count_q    <= '0;
            mag_q      <= '0;
            scratch_q  <= '0;
            neg_q      <= 1'b0;
            bcd_q      <= '0;
            negative_q <= 1'b0;
            blank_q    <= BLANK_RST;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            mag_q      <= mag_d;
            scratch_q  <= scratch_d;
            neg_q      <= neg_d;
            bcd_q      <= bcd_d;
            negative_q <= negative_d;
            blank_q    <= blank_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.bcd_out     = bcd_q;
    assign bus.negative    = negative_q;
    assign bus.digit_blank = blank_q;
endmodule
